// File: rtl/uart_tx_feeder_if.sv
// Byte-feeder bus: system-side push port plus the transmitter start/din/done handshake.
// The feeder itself binds to the slave modport.
interface uart_tx_feeder_if #(
  parameter int ADDR_W = 3
);
  logic              i_push;
  logic [7:0]        i_wdata;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              i_tx_busy;
  logic              i_tx_done;
  logic              o_tx_start;
  logic [7:0]        o_tx_data;
  logic              o_busy;

  modport slave (
    input  i_push, i_wdata, i_tx_busy, i_tx_done,
    output o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data, o_busy
  );

  modport master (
    output i_push, i_wdata, i_tx_busy, i_tx_done,
    input  o_full, o_empty, o_count, o_overflow, o_tx_start, o_tx_data, o_busy
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmitter: pops one byte per frame and holds it on
// din from the pop edge until the edge after the transmitter's frame-complete pulse.
module uart_tx_feeder #(
  parameter int ADDR_W = 3
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_feeder_if.slave bus
);
  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ZERO_CNT = {(ADDR_W+1){1'b0}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_overflow;
  logic [1:0]        r_state;
  logic              r_tx_start;
  logic [7:0]        r_tx_data;
  logic              r_busy;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_nxt;
  logic [1:0]        w_state_nxt;

  // Full is judged on the registered count, so a push while full is dropped even if a pop
  // frees a slot in the same cycle; a busy transmitter blocks the pop.
  always_comb begin
    w_push      = bus.i_push & ~r_full;
    w_pop       = (r_state == ST_IDLE) & ~r_empty & ~bus.i_tx_busy;
    w_count_nxt = r_count;
    w_state_nxt = r_state;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (ADDR_W+1)'(1'b1);
      2'b01:   w_count_nxt = r_count - (ADDR_W+1)'(1'b1);
      default: w_count_nxt = r_count;
    endcase

    case (r_state)
      ST_IDLE: begin
        if (w_pop) w_state_nxt = ST_START;
        else       w_state_nxt = ST_IDLE;
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_tx_done) w_state_nxt = ST_IDLE;
        else               w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Storage carries no reset: resetting the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= bus.i_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr     <= {ADDR_W{1'b0}};
      r_rptr     <= {ADDR_W{1'b0}};
      r_count    <= ZERO_CNT;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_state    <= ST_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_busy     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + ADDR_W'(1'b1);
      if (w_pop) begin
        r_rptr    <= r_rptr + ADDR_W'(1'b1);
        r_tx_data <= r_mem[r_rptr];
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == FULL_CNT);
      r_empty    <= (w_count_nxt == ZERO_CNT);
      r_overflow <= bus.i_push & r_full;
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == ST_START);
      r_busy     <= (w_state_nxt != ST_IDLE) | (w_count_nxt != ZERO_CNT);
    end
  end

  assign bus.o_full     = r_full;
  assign bus.o_empty    = r_empty;
  assign bus.o_count    = r_count;
  assign bus.o_overflow = r_overflow;
  assign bus.o_tx_start = r_tx_start;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_busy     = r_busy;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a behavioural transmitter that pulses done
// a programmable number of clocks after each start.
module tb_uart_tx_feeder;
  localparam int ADDR_W = 3;

  logic clk;
  logic reset;
  uart_tx_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_feeder #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];

  logic       m_busy   = 1'b0;
  logic       m_done   = 1'b0;
  logic       ext_busy = 1'b0;
  logic [7:0] m_cur    = 8'h00;
  int         m_cnt    = 0;
  int         frame_len = 10;
  int         spur_req = 0;
  int         spur_ack = 0;

  assign bus.i_tx_busy = m_busy | ext_busy;
  assign bus.i_tx_done = m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transmitter model: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (reset) begin
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_cnt    = 0;
      spur_ack = spur_req;
    end else begin
      m_done = 1'b0;
      if (bus.o_tx_start && m_busy) begin
        check("start_pulse", bus.o_tx_start, 1'b0);
      end else if (bus.o_tx_start) begin
        if (sb.size() == 0) begin
          check("start_unexpected", sb.size() == 0, 1'b0);
        end else begin
          check("tx_data", bus.o_tx_data, sb.pop_front());
        end
        m_cur  = bus.o_tx_data;
        m_busy = 1'b1;
        m_cnt  = frame_len;
      end else if (m_busy) begin
        check("data_stable", bus.o_tx_data, m_cur);
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (spur_req != spur_ack) begin
        m_done   = 1'b1;
        spur_ack = spur_req;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accept);
    bus.i_push  = 1'b1;
    bus.i_wdata = b;
    if (accept) sb.push_back(b);
    tick();
    bus.i_push  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!bus.o_busy && !m_busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_timeout", ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.i_push  = 1'b0;
    bus.i_wdata = 8'h00;
    repeat (3) tick();

    // Reset state
    check("rst_full",     bus.o_full,     1'b0);
    check("rst_empty",    bus.o_empty,    1'b1);
    check("rst_count",    bus.o_count,    4'd0);
    check("rst_overflow", bus.o_overflow, 1'b0);
    check("rst_start",    bus.o_tx_start, 1'b0);
    check("rst_data",     bus.o_tx_data,  8'h00);
    check("rst_busy",     bus.o_busy,     1'b0);
    reset = 1'b0;
    tick();

    // 1: single byte, latency and hold
    push(8'h41, 1'b1);
    check("t1_count1", bus.o_count,    4'd1);
    check("t1_nostart", bus.o_tx_start, 1'b0);
    check("t1_busy",   bus.o_busy,     1'b1);
    tick();
    check("t1_start",  bus.o_tx_start, 1'b1);
    check("t1_data",   bus.o_tx_data,  8'h41);
    check("t1_count0", bus.o_count,    4'd0);
    tick();
    check("t1_start_low", bus.o_tx_start, 1'b0);
    wait_idle(100);
    check("t1_empty",  bus.o_empty, 1'b1);
    check("t1_idle",   bus.o_busy,  1'b0);

    // 2: fill, overflow, ordered drain
    ext_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i), 1'b1);
    check("t2_full",  bus.o_full,  1'b1);
    check("t2_count", bus.o_count, 4'd8);
    check("t2_ovf_pre", bus.o_overflow, 1'b0);
    push(8'h38, 1'b0);
    check("t2_ovf",   bus.o_overflow, 1'b1);
    check("t2_count_hold", bus.o_count, 4'd8);
    tick();
    check("t2_ovf_once", bus.o_overflow, 1'b0);
    ext_busy = 1'b0;
    wait_idle(400);

    // 3: push coinciding with pop at count 3
    ext_busy = 1'b1;
    for (int i = 0; i < 3; i++) push(8'h50 + 8'(i), 1'b1);
    check("t3_count3", bus.o_count, 4'd3);
    ext_busy = 1'b0;
    push(8'h53, 1'b1);
    check("t3_count_same", bus.o_count,    4'd3);
    check("t3_start",      bus.o_tx_start, 1'b1);
    wait_idle(300);

    // 4: push while full coinciding with pop is dropped
    ext_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i), 1'b1);
    check("t4_full", bus.o_full, 1'b1);
    ext_busy = 1'b0;
    push(8'hEE, 1'b0);
    check("t4_ovf",   bus.o_overflow, 1'b1);
    check("t4_count", bus.o_count,    4'd7);
    check("t4_notfull", bus.o_full,   1'b0);
    wait_idle(400);

    // 5: reset while waiting on a frame with 4 bytes queued
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i), 1'b1);
    check("t5_count4", bus.o_count, 4'd4);
    check("t5_busy",   bus.o_busy,  1'b1);
    reset = 1'b1;
    tick();
    sb.delete();
    check("t5_empty", bus.o_empty,    1'b1);
    check("t5_count", bus.o_count,    4'd0);
    check("t5_start", bus.o_tx_start, 1'b0);
    check("t5_data",  bus.o_tx_data,  8'h00);
    check("t5_busy0", bus.o_busy,     1'b0);
    reset = 1'b0;
    repeat (30) tick();
    check("t5_quiet_count", bus.o_count, 4'd0);
    check("t5_quiet_busy",  bus.o_busy,  1'b0);

    // 6: long frames keep din stable; stray done while idle is ignored
    frame_len = 40;
    push(8'h5A, 1'b1);
    push(8'hA5, 1'b1);
    wait_idle(300);
    check("t6_last_data", bus.o_tx_data, 8'hA5);
    spur_req++;
    repeat (5) tick();
    check("t6_busy",  bus.o_busy,     1'b0);
    check("t6_empty", bus.o_empty,    1'b1);
    check("t6_count", bus.o_count,    4'd0);
    check("t6_start", bus.o_tx_start, 1'b0);
    check("t6_data",  bus.o_tx_data,  8'hA5);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte-buffering stage directly upstream of the UART transmitter.
- Accepts bytes from the system side (sensor/watch formatter) into a synchronous FIFO.
- Pops one byte per frame and drives the transmitter's start/din handshake.
- Holds each byte stable until the transmitter reports frame completion.

Parameters:
ADDR_W, 3, FIFO address width; depth = 2**ADDR_W entries (default 8).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
i_push  input  1  write strobe; one byte per cycle while high
i_wdata  input  8  byte to enqueue, sampled when i_push=1
o_full  output  1  FIFO holds 2**ADDR_W entries
o_empty  output  1  FIFO holds 0 entries
o_count  output  ADDR_W+1  current FIFO occupancy
o_overflow  output  1  one-cycle pulse: push attempted while full
i_tx_busy  input  1  transmitter busy flag
i_tx_done  input  1  transmitter one-cycle frame-complete pulse
o_tx_start  output  1  one-cycle start request to transmitter
o_tx_data  output  8  byte being transmitted, drives transmitter din
o_busy  output  1  high when FIFO non-empty or a frame is in flight

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state is sampled on the rising edge of clk.
- Reset values:
  - o_full=0, o_empty=1, o_count=0, o_overflow=0.
  - o_tx_start=0, o_tx_data=8'h00, o_busy=0.
  - Read/write pointers=0; FSM=IDLE.
- FIFO storage: circular register array with ADDR_W-bit pointers that wrap naturally, plus an (ADDR_W+1)-bit count.
  - full = (count == 2**ADDR_W); empty = (count == 0).
  - Flags and count are registered/derived from the registered count.
- Write rules:
  - A push is accepted iff i_push=1 and o_full=0 at the edge: store, advance wptr, increment count.
  - Push while full is dropped (no state change) and o_overflow=1 in the following cycle only.
  - Push while full with a same-cycle pop is still dropped. Full is evaluated before the pop.
- Read is internal only and occurs in IDLE when empty=0: o_tx_data <= mem[rptr], advance rptr, decrement count.
- Simultaneous accepted push and pop: count unchanged, both pointers advance.
- FSM states:
  - IDLE: if empty=0, pop into o_tx_data -> START. Otherwise stay.
  - START: o_tx_start=1 for exactly this one cycle -> WAIT_DONE.
  - WAIT_DONE: o_tx_start=0; hold o_tx_data unchanged. On i_tx_done=1 -> IDLE.
- o_tx_data must stay constant from the pop edge until the edge after i_tx_done. The transmitter indexes din bit by bit during the frame.
- i_tx_busy is used only for checking: if i_tx_busy=1 while in IDLE with empty=0, stay in IDLE and do not pop. This covers the case where the transmitter is still active externally.
- Latency: a byte pushed at edge E into an empty, idle block is popped at edge E+1. o_tx_start is high during cycle E+1..E+2 and the transmitter samples it at edge E+2.
- Back-to-back: after i_tx_done at edge D, IDLE pops at D+1 and START is at D+1..D+2. Gap between frames is 2 clocks.
- o_busy = (state != IDLE) | ~o_empty, registered alongside the state.
- i_tx_done seen outside WAIT_DONE is ignored.
- Reset mid-frame: FIFO contents are discarded, the FSM returns to IDLE, and o_tx_start is deasserted. The transmitter is reset by the same reset.

Test Plan:
1. Reset, push 8'h41 once -> one o_tx_start pulse 2 edges later with o_tx_data=8'h41. Data is held until i_tx_done, then o_busy=0 and o_empty=1.
2. Push 8 bytes 0x30..0x37 back-to-back, then a 9th (0x38) -> o_full=1 after 8th, o_count=8, o_overflow pulses once. Frames emit 0x30..0x37 in order and 0x38 is never sent.
3. With the FIFO holding 3 bytes, push one byte in the same cycle as a pop -> o_count stays 3. All 4 bytes are transmitted in push order.
4. Fill to full, then push in the same cycle a pop occurs -> push dropped, o_overflow=1, o_count=7 next cycle.
5. Assert reset while in WAIT_DONE with 4 bytes queued -> next cycle: o_empty=1, o_count=0, o_tx_start=0, o_tx_data=0. No further start until a new push.
6. Model the transmitter delaying i_tx_done by 10 bit-times -> o_tx_data is stable for every cycle of the frame. A spurious i_tx_done pulse while in IDLE with the FIFO empty causes no state change.
